// File: rtl/adc_conv_if.sv
// adc_conv_if: scheduler-side bundle of register-block settings, ADC engine handshakes and status.
interface adc_conv_if #(parameter int CNT_W = 16);
    logic [31:0]      m_cyc_t, s_cyc_t;
    logic             stat_clr;
    logic             m_start, m_done, m_valid, m_busy;
    logic [127:0]     m_res, m_data;
    logic             s_start, s_done, s_valid, s_busy;
    logic [23:0]      i_res, v_res, i_data, v_data;
    logic [CNT_W-1:0] m_ovr_cnt, s_ovr_cnt, m_tmo_cnt, s_tmo_cnt;

    modport master (
        input  m_cyc_t, s_cyc_t, stat_clr, m_done, m_res, s_done, i_res, v_res,
        output m_start, m_valid, m_busy, m_data, s_start, s_valid, s_busy, i_data, v_data,
        output m_ovr_cnt, s_ovr_cnt, m_tmo_cnt, s_tmo_cnt
    );
    modport slave (
        output m_cyc_t, s_cyc_t, stat_clr, m_done, m_res, s_done, i_res, v_res,
        input  m_start, m_valid, m_busy, m_data, s_start, s_valid, s_busy, i_data, v_data,
        input  m_ovr_cnt, s_ovr_cnt, m_tmo_cnt, s_tmo_cnt
    );
endinterface

// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler: periodic start/done sequencer for the main and sub ADC engines,
// with result snapshots and saturating overrun/timeout counters.
module adc_conv_chan #(
    parameter int MIN_CYC = 100,
    parameter int TMO_CYC = 10000,
    parameter int CNT_W   = 16,
    parameter int DW      = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      cyc_t,
    input  logic             stat_clr,
    input  logic             done,
    input  logic [DW-1:0]    res,
    output logic             start,
    output logic             valid,
    output logic             busy,
    output logic [DW-1:0]    data,
    output logic [CNT_W-1:0] ovr_cnt,
    output logic [CNT_W-1:0] tmo_cnt
);
    localparam int TW = $clog2(TMO_CYC + 1);
    typedef enum logic [1:0] {IDLE, WAIT, START, CONV} state_t;
    state_t        state;
    logic [31:0]   cnt, per_m1;
    logic [TW-1:0] tmo;
    logic          en, tick, pend, ovr_inc, tmo_inc;

    assign en      = cyc_t != '0;
    assign per_m1  = (cyc_t < 32'(MIN_CYC)) ? 32'(MIN_CYC - 1) : cyc_t - 32'd1;
    assign tick    = state != IDLE && cnt == '0;
    assign ovr_inc = en && state == CONV && tick && !done;
    // tmo counts clocks since the start pulse, the start cycle itself being clock 1
    assign tmo_inc = en && state == CONV && !done && tmo == TW'(TMO_CYC - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            tmo     <= '0;
            pend    <= 1'b0;
            start   <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            data    <= '0;
            ovr_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            pend    <= 1'b0;
            valid   <= pend;
            start   <= 1'b0;
            tmo     <= (state == START) ? TW'(1) : (state == CONV) ? tmo + 1'b1 : '0;
            cnt     <= (state == IDLE) ? (en ? per_m1 : cnt) : (tick ? per_m1 : cnt - 32'd1);
            ovr_cnt <= stat_clr ? '0 : ovr_cnt + CNT_W'(ovr_inc && !(&ovr_cnt));
            tmo_cnt <= stat_clr ? '0 : tmo_cnt + CNT_W'(tmo_inc && !(&tmo_cnt));
            if (!en) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE:  state <= WAIT;
                    WAIT:  if (tick) begin
                        state <= START;
                        start <= 1'b1;
                    end
                    START: begin
                        state <= CONV;
                        busy  <= 1'b1;
                    end
                    CONV:  if (done) begin
                        data  <= res;
                        pend  <= 1'b1;
                        state <= tick ? START : WAIT;
                        start <= tick;
                        busy  <= 1'b0;
                    end else if (tmo_inc) begin
                        state <= WAIT;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

module adc_conv_scheduler #(
    parameter int MIN_CYC = 100,
    parameter int TMO_CYC = 10000,
    parameter int CNT_W   = 16
) (
    input logic         clk,
    input logic         rst_n,
    adc_conv_if.master  bus
);
    logic [47:0] s_data;

    assign {bus.v_data, bus.i_data} = s_data;

    adc_conv_chan #(.MIN_CYC(MIN_CYC), .TMO_CYC(TMO_CYC), .CNT_W(CNT_W), .DW(128)) u_main (
        .clk(clk), .rst_n(rst_n), .cyc_t(bus.m_cyc_t), .stat_clr(bus.stat_clr),
        .done(bus.m_done), .res(bus.m_res), .start(bus.m_start), .valid(bus.m_valid),
        .busy(bus.m_busy), .data(bus.m_data), .ovr_cnt(bus.m_ovr_cnt), .tmo_cnt(bus.m_tmo_cnt)
    );

    adc_conv_chan #(.MIN_CYC(MIN_CYC), .TMO_CYC(TMO_CYC), .CNT_W(CNT_W), .DW(48)) u_sub (
        .clk(clk), .rst_n(rst_n), .cyc_t(bus.s_cyc_t), .stat_clr(bus.stat_clr),
        .done(bus.s_done), .res({bus.v_res, bus.i_res}), .start(bus.s_start), .valid(bus.s_valid),
        .busy(bus.s_busy), .data(s_data), .ovr_cnt(bus.s_ovr_cnt), .tmo_cnt(bus.s_tmo_cnt)
    );
endmodule

// File: tb/tb_adc_conv_scheduler.sv
// tb_adc_conv_scheduler: directed checks of period, clamp, overrun, timeout, clear,
// coincident done/tick, spurious done, disable and async reset.
module tb_adc_conv_scheduler;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   t, prev, t_en, n;
    logic [127:0] mv;
    logic [23:0]  iv, vv;

    adc_conv_if #(.CNT_W(16)) bus();
    adc_conv_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input bit sub, input int lim, output int ts);
        ts = -1;
        for (int i = 0; i < lim && ts < 0; i++) begin
            @(negedge clk);
            if (sub ? bus.s_start : bus.m_start) ts = cyc;
        end
        check(sub ? "s_start_seen" : "m_start_seen", 128'(ts >= 0), 1);
    endtask

    task automatic m_done_pulse(input logic [127:0] v);
        bus.m_done = 1'b1;
        bus.m_res  = v;
        @(negedge clk);
        bus.m_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.m_cyc_t = '0; bus.s_cyc_t = '0; bus.stat_clr = 1'b0;
        bus.m_done = 1'b0; bus.m_res = '0;
        bus.s_done = 1'b0; bus.i_res = '0; bus.v_res = '0;
        repeat (3) @(negedge clk);
        check("rst_m_start", bus.m_start, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_m_busy", bus.m_busy, 0);
        check("rst_s_i_data", bus.i_data, 0);
        check("rst_m_ovr", bus.m_ovr_cnt, 0);
        check("rst_s_tmo", bus.s_tmo_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // normal operation: period 200, done 50 clocks after start
        bus.m_cyc_t = 200;
        t_en = cyc + 1;
        wait_start(0, 300, t);
        check("m_first_start", 128'(t - t_en), 200);
        for (int k = 0; k < 3; k++) begin
            repeat (50) @(negedge clk);
            check("m_busy_conv", bus.m_busy, 1);
            mv = {4{32'hA5A5_0000 + 32'(k)}};
            m_done_pulse(mv);
            check("m_data_latch", bus.m_data, mv);
            check("m_valid_early", bus.m_valid, 0);
            @(negedge clk);
            check("m_valid_pulse", bus.m_valid, 1);
            check("m_busy_wait", bus.m_busy, 0);
            prev = t;
            wait_start(0, 300, t);
            check("m_period_200", 128'(t - prev), 200);
        end
        check("m_ovr_zero", bus.m_ovr_cnt, 0);
        check("m_tmo_zero", bus.m_tmo_cnt, 0);

        // overrun: done 450 clocks after start -> two skipped ticks, period 600
        for (int k = 1; k <= 2; k++) begin
            repeat (450) @(negedge clk);
            m_done_pulse({4{32'h0BAD_0000 + 32'(k)}});
            check("m_ovr_cnt", bus.m_ovr_cnt, 128'(2 * k));
            prev = t;
            wait_start(0, 700, t);
            check("m_period_600", 128'(t - prev), 600);
        end
        bus.m_cyc_t = 0;
        repeat (2) @(negedge clk);
        check("m_idle_busy", bus.m_busy, 0);

        // timeout with done withheld, then clears
        bus.stat_clr = 1'b1;
        @(negedge clk);
        bus.stat_clr = 1'b0;
        check("clr_ovr", bus.m_ovr_cnt, 0);
        bus.m_cyc_t = 300;
        wait_start(0, 400, t);
        repeat (9999) @(negedge clk);
        check("tmo_before", bus.m_tmo_cnt, 0);
        check("tmo_busy", bus.m_busy, 1);
        check("tmo_ovr33", bus.m_ovr_cnt, 33);
        @(negedge clk);
        check("tmo_hit", bus.m_tmo_cnt, 1);
        check("tmo_idle", bus.m_busy, 0);
        prev = t;
        wait_start(0, 400, t);
        check("tmo_next_start", 128'(t - prev), 10200);
        repeat (299) @(negedge clk);
        bus.stat_clr = 1'b1;
        @(negedge clk);
        bus.stat_clr = 1'b0;
        check("clr_vs_inc_ovr", bus.m_ovr_cnt, 0);
        check("clr_tmo", bus.m_tmo_cnt, 0);
        repeat (300) @(negedge clk);
        check("ovr_after_clr", bus.m_ovr_cnt, 1);
        bus.m_cyc_t = 0;
        repeat (2) @(negedge clk);

        // done coincident with tick, then spurious done in WAIT
        bus.m_cyc_t = 200;
        wait_start(0, 300, t);
        repeat (199) @(negedge clk);
        m_done_pulse({4{32'hC0DE_0005}});
        check("coinc_start", bus.m_start, 1);
        check("coinc_data", bus.m_data, {4{32'hC0DE_0005}});
        check("coinc_ovr", bus.m_ovr_cnt, 1);
        @(negedge clk);
        check("coinc_valid", bus.m_valid, 1);
        repeat (48) @(negedge clk);
        m_done_pulse({4{32'hC0DE_0006}});
        repeat (3) @(negedge clk);
        m_done_pulse({4{32'hDEAD_0007}});
        check("spur_data", bus.m_data, {4{32'hC0DE_0006}});
        check("spur_valid0", bus.m_valid, 0);
        @(negedge clk);
        check("spur_valid1", bus.m_valid, 0);

        // async reset mid-conversion
        wait_start(0, 300, t);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", bus.m_busy, 0);
        check("arst_data", bus.m_data, 0);
        check("arst_ovr", bus.m_ovr_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        t_en = cyc + 1;
        @(negedge clk);
        m_done_pulse({4{32'h1234_5678}});
        check("arst_done_data", bus.m_data, 0);
        check("arst_done_valid", bus.m_valid, 0);
        @(negedge clk);
        check("arst_done_valid2", bus.m_valid, 0);
        wait_start(0, 300, t);
        check("arst_first_start", 128'(t - t_en), 200);

        // sub channel: clamped period, latch, disable in flight
        bus.s_cyc_t = 20;
        t_en = cyc + 1;
        wait_start(1, 200, t);
        check("s_first_start", 128'(t - t_en), 100);
        for (int k = 0; k < 2; k++) begin
            repeat (10) @(negedge clk);
            iv = 24'h123450 + 24'(k);
            vv = 24'hABC000 + 24'(k);
            bus.s_done = 1'b1; bus.i_res = iv; bus.v_res = vv;
            @(negedge clk);
            bus.s_done = 1'b0;
            check("s_i_data", bus.i_data, iv);
            check("s_v_data", bus.v_data, vv);
            @(negedge clk);
            check("s_valid", bus.s_valid, 1);
            prev = t;
            wait_start(1, 200, t);
            check("s_period_100", 128'(t - prev), 100);
        end
        repeat (5) @(negedge clk);
        bus.s_cyc_t = 0;
        @(negedge clk);
        check("s_dis_busy", bus.s_busy, 0);
        bus.s_done = 1'b1; bus.i_res = 24'hFFFFFF; bus.v_res = 24'hEEEEEE;
        @(negedge clk);
        bus.s_done = 1'b0;
        check("s_late_i", bus.i_data, iv);
        check("s_late_v", bus.v_data, vv);
        @(negedge clk);
        check("s_late_valid", bus.s_valid, 0);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n += int'(bus.s_start);
        end
        check("s_dis_starts", 128'(n), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
